// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command definition plus the scheduler's state type and defaults.
package frontend_command_definition_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [27:0] addr;
  } frontend_command_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } sched_state_t;

  localparam int SCHED_WRITE_BURST_MAX = 8;
  localparam int SCHED_TURNAROUND      = 2;
  localparam int SCHED_TURN_CNT_W      = 8;

endpackage

// File: rtl/rw_request_scheduler_turnaround_counter.sv
// Loadable down-counter that saturates at zero; used for bus timing gaps.
module turnaround_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/rw_request_scheduler.sv
// Read-priority command scheduler: issues from the read and write request FIFOs into one
// registered valid/ready slot, with bounded write bursts and a direction-change gap.
module rw_request_scheduler
  import frontend_command_definition_pkg::*;
#(
  parameter int WRITE_BURST_MAX   = SCHED_WRITE_BURST_MAX,
  parameter int TURNAROUND_CYCLES = SCHED_TURNAROUND,
  parameter int BURST_CNT_W       = $clog2(WRITE_BURST_MAX + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_empty,
  input  frontend_command_t i_rd_data,
  output logic              o_rd_pop,
  input  logic              i_wr_empty,
  input  frontend_command_t i_wr_data,
  input  logic              i_wr_flush,
  input  logic              i_raw_pending,
  output logic              o_wr_pop,
  output logic              o_cmd_valid,
  output frontend_command_t o_cmd,
  output logic              o_cmd_is_write,
  input  logic              i_cmd_ready,
  output logic              o_write_mode
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX_C = BURST_CNT_W'(WRITE_BURST_MAX);

  sched_state_t            state_q, state_d;
  logic                    target_write_q, target_write_d;
  logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic                    raw_lock_q, raw_lock_d;
  logic                    flush_q;
  logic                    cmd_valid_q;
  frontend_command_t       cmd_q;
  logic                    cmd_is_write_q;
  logic                    write_mode_q;

  logic can_load_s, rd_pop_s, wr_pop_s, both_empty_s;
  logic rd_go_write_s, wr_go_read_s;
  logic turn_load_s, turn_dec_s, turn_zero_s;

  assign can_load_s   = !cmd_valid_q || i_cmd_ready;
  assign both_empty_s = i_rd_empty && i_wr_empty;
  // A flush edge (not level) preempts reads, so a watermark that stays high across a
  // burst-limit return to READ does not bounce straight back to WRITE.
  assign rd_go_write_s = !i_wr_empty && ((i_wr_flush && !flush_q) || i_rd_empty);
  assign wr_go_read_s  = !i_rd_empty &&
                         (i_wr_empty || ((burst_cnt_q == BURST_MAX_C) && !raw_lock_q));

  turnaround_counter #(.W(SCHED_TURN_CNT_W)) u_turn_cnt (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (turn_load_s),
    .load_val_i (SCHED_TURN_CNT_W'(TURNAROUND_CYCLES)),
    .dec_i      (turn_dec_s),
    .zero_o     (turn_zero_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      target_write_q <= 1'b0;
      burst_cnt_q    <= {BURST_CNT_W{1'b0}};
      raw_lock_q     <= 1'b0;
      flush_q        <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= '0;
      cmd_is_write_q <= 1'b0;
      write_mode_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_write_q <= target_write_d;
      burst_cnt_q    <= burst_cnt_d;
      raw_lock_q     <= raw_lock_d;
      flush_q        <= i_wr_flush;
      write_mode_q   <= (state_d == WRITE);
      if (rd_pop_s || wr_pop_s) begin
        cmd_valid_q    <= 1'b1;
        cmd_q          <= wr_pop_s ? i_wr_data : i_rd_data;
        cmd_is_write_q <= wr_pop_s;
      end else if (i_cmd_ready) begin
        cmd_valid_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    target_write_d = target_write_q;
    turn_load_s    = 1'b0;
    turn_dec_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wr_flush && !i_wr_empty)  state_d = WRITE;
        else if (!i_rd_empty)           state_d = READ;
        else if (!i_wr_empty)           state_d = WRITE;
        else                            state_d = IDLE;
      end
      READ: begin
        if (rd_go_write_s) begin
          state_d        = TURN;
          target_write_d = 1'b1;
          turn_load_s    = 1'b1;
        end else if (both_empty_s) begin
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (wr_go_read_s) begin
          state_d        = TURN;
          target_write_d = 1'b0;
          turn_load_s    = 1'b1;
        end else if (both_empty_s) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      TURN: begin
        if (can_load_s) begin
          if (turn_zero_s) state_d = target_write_q ? WRITE : READ;
          else             turn_dec_s = 1'b1;
        end else begin
          state_d = TURN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_pop_s    = can_load_s && (state_q == READ)  && !i_rd_empty && !rd_go_write_s;
    wr_pop_s    = can_load_s && (state_q == WRITE) && !i_wr_empty && !wr_go_read_s;
    burst_cnt_d = burst_cnt_q;
    raw_lock_d  = raw_lock_q;
    if (state_q != WRITE) begin
      burst_cnt_d = {BURST_CNT_W{1'b0}};
    end else if (wr_pop_s && (burst_cnt_q != BURST_MAX_C)) begin
      burst_cnt_d = burst_cnt_q + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
    if (state_d != WRITE) begin
      raw_lock_d = 1'b0;
    end else begin
      raw_lock_d = raw_lock_q || i_raw_pending;
    end
  end

  assign o_rd_pop       = rd_pop_s;
  assign o_wr_pop       = wr_pop_s;
  assign o_cmd_valid    = cmd_valid_q;
  assign o_cmd          = cmd_q;
  assign o_cmd_is_write = cmd_is_write_q;
  assign o_write_mode   = write_mode_q;

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Self-checking bench: queue-based FIFO models and a per-stream scoreboard drive the scheduler.
module tb_rw_request_scheduler;
  import frontend_command_definition_pkg::*;

  localparam int WB = 8;
  localparam int TA = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rd_empty, wr_empty, wr_flush, raw_pending, cmd_ready;
  frontend_command_t rd_data, wr_data, o_cmd;
  logic o_rd_pop, o_wr_pop, o_cmd_valid, o_cmd_is_write, o_write_mode;

  always #5 clk = ~clk;

  rw_request_scheduler #(.WRITE_BURST_MAX(WB), .TURNAROUND_CYCLES(TA)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_empty(rd_empty), .i_rd_data(rd_data), .o_rd_pop(o_rd_pop),
    .i_wr_empty(wr_empty), .i_wr_data(wr_data), .i_wr_flush(wr_flush),
    .i_raw_pending(raw_pending), .o_wr_pop(o_wr_pop),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_cmd_is_write(o_cmd_is_write),
    .i_cmd_ready(cmd_ready), .o_write_mode(o_write_mode)
  );

  frontend_command_t rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];
  bit seq[$];
  bit exp_seq[$];
  int acc_cyc[$];
  int pop_cyc[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit flush_en = 1'b0;
  bit gap_en = 1'b0;
  bit prev_stall = 1'b0;
  frontend_command_t prev_cmd;
  bit have_last = 1'b0;
  bit last_w = 1'b0;
  int last_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rd_empty = (rd_q.size() == 0);
    wr_empty = (wr_q.size() == 0);
    rd_data  = (rd_q.size() != 0) ? rd_q[0] : '0;
    wr_data  = (wr_q.size() != 0) ? wr_q[0] : '0;
    wr_flush = flush_en && (wr_q.size() != 0);
  endtask

  task automatic push_rd(input int n);
    frontend_command_t c;
    for (int i = 0; i < n; i++) begin
      c = frontend_command_t'($urandom());
      rd_q.push_back(c);
      exp_rd.push_back(c);
    end
    drive();
  endtask

  task automatic push_wr(input int n);
    frontend_command_t c;
    for (int i = 0; i < n; i++) begin
      c = frontend_command_t'($urandom());
      wr_q.push_back(c);
      exp_wr.push_back(c);
    end
    drive();
  endtask

  // One clock: sample the handshake on the falling edge, then apply FIFO pops after the rising edge.
  task automatic tick();
    logic pr, pw, acc, w;
    frontend_command_t c;
    @(negedge clk);
    pr  = o_rd_pop;
    pw  = o_wr_pop;
    acc = o_cmd_valid && cmd_ready;
    w   = o_cmd_is_write;
    c   = o_cmd;
    if (prev_stall) begin
      chk("stall_valid", 64'(o_cmd_valid), 64'(1));
      chk("stall_cmd", 64'(o_cmd), 64'(prev_cmd));
    end
    prev_stall = o_cmd_valid && !cmd_ready;
    prev_cmd   = c;
    if (pr && pw) chk("dual_pop", 64'(1), 64'(0));
    if (pr) begin
      chk("rd_pop_nonempty", 64'(rd_q.size() != 0), 64'(1));
      pop_cyc.push_back(cyc);
    end
    if (pw) chk("wr_pop_nonempty", 64'(wr_q.size() != 0), 64'(1));
    if (acc) begin
      if (w) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(1), 64'(0));
        else chk("wr_cmd", 64'(c), 64'(exp_wr.pop_front()));
      end else begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
        else chk("rd_cmd", 64'(c), 64'(exp_rd.pop_front()));
      end
      if (gap_en && have_last && (last_w != w))
        chk("turn_gap", 64'((cyc - last_cyc) >= TA + 2), 64'(1));
      seq.push_back(w);
      acc_cyc.push_back(cyc);
      have_last = 1'b1;
      last_w    = w;
      last_cyc  = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pr && rd_q.size() != 0) void'(rd_q.pop_front());
    if (pw && wr_q.size() != 0) void'(wr_q.pop_front());
    drive();
  endtask

  task automatic run_until(input string tag, input int target, input int budget);
    int t = 0;
    while (seq.size() < target && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 64'(seq.size()), 64'(target));
  endtask

  task automatic clear_all();
    rd_q.delete(); wr_q.delete(); exp_rd.delete(); exp_wr.delete();
    seq.delete(); acc_cyc.delete(); pop_cyc.delete();
    flush_en = 1'b0; raw_pending = 1'b0; gap_en = 1'b0;
    prev_stall = 1'b0; have_last = 1'b0;
    drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(o_cmd_valid), 64'(0));
    chk({tag, "_cmd"}, 64'(o_cmd), 64'(0));
    chk({tag, "_is_write"}, 64'(o_cmd_is_write), 64'(0));
    chk({tag, "_write_mode"}, 64'(o_write_mode), 64'(0));
    chk({tag, "_rd_pop"}, 64'(o_rd_pop), 64'(0));
    chk({tag, "_wr_pop"}, 64'(o_wr_pop), 64'(0));
  endtask

  // Reset is asserted asynchronously between edges; queues model FIFOs sharing the reset.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    clear_all();
    cmd_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 64'(seq.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
      chk({tag, "_type"}, 64'(seq[i]), 64'(exp_seq[i]));
  endtask

  task automatic burst_case(input string tag, input bit raw, input int nw, input int nr);
    int first;
    do_reset({tag, "_rst"});
    flush_en = 1'b1; raw_pending = raw; gap_en = 1'b1;
    push_wr(nw);
    push_rd(nr);
    first = raw ? nw : ((nw < WB) ? nw : WB);
    exp_seq.delete();
    for (int i = 0; i < first; i++) exp_seq.push_back(1'b1);
    for (int i = 0; i < nr; i++) exp_seq.push_back(1'b0);
    for (int i = 0; i < nw - first; i++) exp_seq.push_back(1'b1);
    run_until({tag, "_done"}, nw + nr, 400);
    check_seq(tag);
  endtask

  initial begin
    int t0, k, t, stall_pops, n_rd, n_wr;
    rst_n = 1'b0; cmd_ready = 1'b1; raw_pending = 1'b0;
    clear_all();
    @(posedge clk);
    #1;
    do_reset("reset");

    // Reads only, checking latency and back-to-back pops
    t0 = cyc;
    push_rd(5);
    run_until("rd_only_done", 5, 100);
    exp_seq.delete();
    for (int i = 0; i < 5; i++) exp_seq.push_back(1'b0);
    check_seq("rd_only");
    chk("rd_only_first_pop", 64'(pop_cyc.size() != 0 ? pop_cyc[0] : -1), 64'(t0 + 1));
    chk("rd_only_first_valid", 64'(acc_cyc.size() != 0 ? acc_cyc[0] : -1), 64'(t0 + 2));
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("rd_only_pop_consec", 64'(pop_cyc[i]), 64'(pop_cyc[0] + i));

    // Flush rising during a read stream
    do_reset("flush_rst");
    gap_en = 1'b1;
    push_rd(6);
    run_until("flush_pre", 2, 100);
    push_wr(4);
    flush_en = 1'b1;
    drive();
    run_until("flush_done", 10, 400);
    k = 0;
    while (k < seq.size() && seq[k] == 1'b0) k++;
    chk("flush_held_reads", 64'(k >= 2 && k <= 3), 64'(1));
    exp_seq.delete();
    for (int i = 0; i < k; i++) exp_seq.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_seq.push_back(1'b1);
    for (int i = 0; i < 6 - k; i++) exp_seq.push_back(1'b0);
    check_seq("flush");

    burst_case("burst", 1'b0, 12, 3);
    burst_case("raw_lock", 1'b1, 12, 3);

    // Backpressure with the slot full
    do_reset("bp_rst");
    push_rd(6);
    run_until("bp_pre", 1, 100);
    cmd_ready = 1'b0;
    stall_pops = pop_cyc.size();
    repeat (4) tick();
    chk("bp_no_pop", 64'(pop_cyc.size()), 64'(stall_pops));
    chk("bp_no_accept", 64'(seq.size()), 64'(1));
    cmd_ready = 1'b1;
    run_until("bp_done", 6, 100);
    exp_seq.delete();
    for (int i = 0; i < 6; i++) exp_seq.push_back(1'b0);
    check_seq("bp");

    // Random traffic, readiness, flush and RAW
    do_reset("rand_rst");
    n_rd = 0; n_wr = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin push_rd(1); n_rd++; end
      if ($urandom_range(0, 3) == 0) begin push_wr(1); n_wr++; end
      cmd_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) flush_en = ~flush_en;
      raw_pending = ($urandom_range(0, 7) == 0);
      drive();
      tick();
    end
    cmd_ready = 1'b1;
    raw_pending = 1'b0;
    run_until("rand_done", n_rd + n_wr, 2000);
    chk("rand_rd_left", 64'(exp_rd.size()), 64'(0));
    chk("rand_wr_left", 64'(exp_wr.size()), 64'(0));

    // Asynchronous reset in the middle of a write burst
    do_reset("mid_rst_pre");
    flush_en = 1'b1;
    push_wr(10);
    push_rd(2);
    t = 0;
    while (t < 50 && !(o_cmd_valid && o_write_mode)) begin
      tick();
      t++;
    end
    chk("mid_burst_reached", 64'(o_cmd_valid && o_write_mode), 64'(1));
    tick();
    do_reset("mid_reset");
    repeat (3) tick();
    chk("post_reset_idle_accepts", 64'(seq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rw_request_scheduler.md
# rw_request_scheduler

Read/write command scheduler between the frontend request FIFOs and the backend command port. It pops `frontend_command_t` entries from the read request FIFO and the `write_request_fifo`, then presents one command at a time on a registered valid/ready port. Reads are prioritised. The write FIFO's flush indication (RAW hazard or watermark) forces write-drain mode. A bounded write burst and a bus-turnaround gap keep reads from starving.

## Interface
Parameters:
- `WRITE_BURST_MAX`, default 8: maximum writes issued per write-mode visit while reads are pending, unless the flush is RAW-driven.
- `TURNAROUND_CYCLES`, default 2: idle cycles inserted on each read↔write direction change; 0 means no gap.
- `BURST_CNT_W`, default `$clog2(WRITE_BURST_MAX+1)`.

Ports (clock and reset first):
- `i_clk` in 1: single clock. All logic is on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_rd_empty` in 1: read FIFO empty.
- `i_rd_data` in `frontend_command_t`: read FIFO head, combinational from the FIFO.
- `o_rd_pop` out 1: read FIFO `rd_en`.
- `i_wr_empty` in 1: write FIFO `o_empty`.
- `i_wr_data` in `frontend_command_t`: write FIFO head (`o_data`).
- `i_wr_flush` in 1: write FIFO `o_write_flush`.
- `i_raw_pending` in 1: same RAW flag that feeds the write FIFO's `i_raw_flag`. When latched, it disables the burst limit.
- `o_wr_pop` out 1: write FIFO `rd_en`.
- `o_cmd_valid` out 1: backend command valid.
- `o_cmd` out `frontend_command_t`: registered command.
- `o_cmd_is_write` out 1: 1 means `o_cmd` came from the write FIFO.
- `i_cmd_ready` in 1: backend accepts `o_cmd` this cycle.
- `o_write_mode` out 1: the FSM is in WRITE.

## Operation
- FSM states: IDLE, READ, WRITE, TURN.
- Issue slot: one output register.
  - `load = (!o_cmd_valid || i_cmd_ready) && source_selected`.
  - `o_rd_pop` and `o_wr_pop` equal `load` gated by the source. They are never both 1 and never asserted when the source FIFO is empty.
- IDLE:
  - If `i_wr_flush` is set and the write FIFO is non-empty, go to WRITE.
  - Otherwise, if the read FIFO is non-empty, go to READ.
  - Otherwise, if the write FIFO is non-empty, go to WRITE.
  - IDLE issues nothing. There is no turnaround from IDLE.
- READ:
  - Pops and issues reads while `!i_rd_empty`.
  - If `i_wr_flush` rises, or the read FIFO is empty while writes are pending, go to TURN with target WRITE. A command already in the slot stays until accepted.
  - If both FIFOs are empty, go to IDLE.
- WRITE:
  - Pops and issues writes. `burst_cnt` increments on each write pop and clears on entry.
  - Exit to TURN with target READ when either:
    - the write FIFO is empty and the read FIFO is non-empty; or
    - `burst_cnt == WRITE_BURST_MAX` with reads pending and `raw_lock == 0`.
  - If both FIFOs are empty, go to IDLE.
  - `raw_lock` is set on entry if `i_raw_pending` is high, and is set whenever `i_raw_pending` is sampled high in WRITE. It clears on leaving WRITE.
  - If `i_wr_flush` is high and no reads are pending, stay.
- TURN:
  - Waits until the slot is drained (`!o_cmd_valid`).
  - Then counts `TURNAROUND_CYCLES` cycles and goes to the target.
  - No pops occur in TURN.
  - If the target FIFO empties during TURN, the FSM still enters the target state, which re-evaluates the next cycle.
- Priority when both FIFOs are non-empty and `i_wr_flush` is low: reads.
- Data integrity: the command is captured from the head in the same cycle as the pop. `o_cmd` is stable while `o_cmd_valid && !i_cmd_ready`.

## Timing
- Reset values: FSM IDLE, `o_cmd_valid` 0, `o_cmd` 0, `o_cmd_is_write` 0, `o_write_mode` 0, `o_rd_pop` 0, `o_wr_pop` 0, counters 0, `raw_lock` 0.
- Latency:
  - FIFO goes non-empty in cycle N → FSM leaves IDLE at N+1.
  - Pop at N+1 → `o_cmd_valid` at N+2.
- Throughput: one command per cycle in steady READ or WRITE with `i_cmd_ready` held high.
- Direction change: last accepted command → first command of the other type after `TURNAROUND_CYCLES + 2` cycles.
- `o_write_mode` is registered and equals (state == WRITE).
- Pop outputs are combinational from state, empties and `i_cmd_ready`. There is no combinational path from `i_*_data` to any output.
- An asynchronous reset mid-burst drops the slot contents. FIFO pointers are reset by the same `i_rst_n`.

## Structure
- `frontend_command_t` comes from `frontend_command_definition_pkg`.
- Add to the shared package:
  - `sched_state_t` enum (IDLE, READ, WRITE, TURN);
  - default constants `SCHED_WRITE_BURST_MAX` and `SCHED_TURNAROUND`.
- Single module. A small `turnaround_counter` sub-module (load/decrement/zero) is natural and reusable for the timing-constraint counters.

## Test plan
- Reset: assert `i_rst_n=0` mid-stream → all outputs 0 and state IDLE on the next edge, with no pops.
- Reads only: 5 reads, `i_cmd_ready=1` → 5 pops on consecutive cycles, `o_cmd` matches in order, `o_cmd_is_write=0` throughout.
- Flush during reads: 6 reads queued, `i_wr_flush` rises after read 2 with 4 writes queued → remaining reads held, TURN for 2 cycles, 4 writes issued, TURN, remaining 4 reads issued.
- Burst limit: 12 writes with flush (watermark), 3 reads pending, `i_raw_pending=0` → exactly 8 writes, turnaround, 3 reads, turnaround, last 4 writes.
- RAW lock: same setup with `i_raw_pending=1` at entry → all 12 writes issued before any read.
- Backpressure: `i_cmd_ready=0` for 4 cycles with the slot full → `o_cmd` stable, no pops; resume → no loss or duplication; the FIFO never sees a pop while empty.
